// File: rtl/multdiv_sequencer_pkg.sv
// multdiv_sequencer_pkg: shared constants for the mult/div sequencer and the decoder.
package multdiv_sequencer_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } md_state_t;
  localparam logic [4:0] REG_RSTATUS       = 5'd30;
  localparam int         RSTATUS_MULT_DEF  = 4;
  localparam int         RSTATUS_DIV_DEF   = 5;
  localparam logic [4:0] OPC_RTYPE         = 5'b00000;
  localparam logic [4:0] ALU_MULT          = 5'b00110;
  localparam logic [4:0] ALU_DIV           = 5'b00111;
endpackage

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: issues a mult/div to the iterative unit, stalls the front end
// until it finishes or times out, then writes rd (or r30 status on exception).
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int MAX_CYCLES   = 40,
  parameter int CNT_W        = 6,
  parameter int RSTATUS_MULT = RSTATUS_MULT_DEF,
  parameter int RSTATUS_DIV  = RSTATUS_DIV_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic        x_mult,
  input  logic        x_div,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_opA,
  input  logic [31:0] x_opB,
  input  logic        x_flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall_fd,
  output logic        bubble_dx,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack,
  output logic        busy
);
  md_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d, exc_q, exc_d;
  logic        start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rd_d    = rd_q;
    div_d   = div_q;
    exc_d   = exc_q;
    // reset gating keeps start (and the stall it drives) low while reset is held
    start   = reset & (state_q == S_IDLE) & x_valid & (x_mult | x_div) & ~x_flush;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ISSUE;
        opa_d   = x_opA;
        opb_d   = x_opB;
        rd_d    = x_rd;
        div_d   = ~x_mult;
        cnt_d   = '0;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (md_ready) begin
          res_d   = md_result;
          exc_d   = md_exception;
          state_d = S_WRITE;
        end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          exc_d   = 1'b1;
          state_d = S_WRITE;
        end
      end
      default: if (wb_ack) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      exc_q   <= exc_d;
    end
  end

  assign busy         = state_q != S_IDLE;
  assign stall_fd     = start | busy;
  assign bubble_dx    = start | busy;
  assign md_ctrl_mult = (state_q == S_ISSUE) & ~div_q;
  assign md_ctrl_div  = (state_q == S_ISSUE) & div_q;
  assign md_opA       = opa_q;
  assign md_opB       = opb_q;
  assign wb_valid     = state_q == S_WRITE;
  assign wb_rd        = !wb_valid ? 5'd0 : exc_q ? REG_RSTATUS : rd_q;
  assign wb_data      = !wb_valid ? 32'd0 : !exc_q ? res_q :
                        div_q ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MULT);
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;
  logic        clock = 1'b0, reset = 1'b0;
  logic        x_valid = 0, x_mult = 0, x_div = 0, x_flush = 0;
  logic [4:0]  x_rd = 0;
  logic [31:0] x_opA = 0, x_opB = 0, md_result = 0;
  logic        md_exception = 0, md_ready = 0, wb_ack = 0;
  logic        md_ctrl_mult, md_ctrl_div, stall_fd, bubble_dx, wb_valid, busy;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_rd;
  int n_chk = 0, n_err = 0, n_mult = 0, n_div = 0, n_wr5 = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .x_valid(x_valid), .x_mult(x_mult), .x_div(x_div),
    .x_rd(x_rd), .x_opA(x_opA), .x_opB(x_opB), .x_flush(x_flush),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_opA(md_opA), .md_opB(md_opB),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .stall_fd(stall_fd), .bubble_dx(bubble_dx), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_ack(wb_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (md_ctrl_mult) n_mult++;
    if (md_ctrl_div) n_div++;
  end
  always @(posedge clock) if (reset && wb_valid && wb_ack && wb_rd == 5'd5) n_wr5++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic m, input logic d, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    x_valid = 1; x_mult = m; x_div = d; x_rd = rd; x_opA = a; x_opB = b;
    #1;
    check("start_stall", stall_fd, 1);
    check("start_bubble", bubble_dx, 1);
    step();
    x_valid = 0; x_mult = 0; x_div = 0;
  endtask

  initial begin
    @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_stall", stall_fd, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_opA", md_opA, 0);
    reset = 1;
    step();

    // mult 7*6 -> r3, ready after 16 cycles
    issue(1, 0, 5'd3, 32'd7, 32'd6);
    check("mul_pulse", md_ctrl_mult, 1);
    check("mul_opA", md_opA, 7);
    check("mul_opB", md_opB, 6);
    md_ready = 1;
    step();
    md_ready = 0;
    for (int i = 0; i < 15; i++) begin
      check("mul_wait_stall", stall_fd, 1);
      check("mul_wait_wbv", wb_valid, 0);
      step();
    end
    md_ready = 1; md_result = 42;
    step();
    md_ready = 0;
    check("mul_wbv", wb_valid, 1);
    check("mul_wbrd", wb_rd, 3);
    check("mul_wbdata", wb_data, 42);
    check("mul_wr_stall", stall_fd, 1);
    wb_ack = 1;
    step();
    wb_ack = 0;
    check("mul_done_stall", stall_fd, 0);
    check("mul_done_busy", busy, 0);
    check("mul_pulses", n_mult, 1);

    // div by zero -> exception status in r30
    issue(0, 1, 5'd5, 32'd100, 32'd0);
    check("div_pulse", md_ctrl_div, 1);
    step();
    md_ready = 1; md_exception = 1;
    step();
    md_ready = 0; md_exception = 0;
    check("div_wbrd", wb_rd, 30);
    check("div_wbdata", wb_data, 5);
    wb_ack = 1;
    step();
    wb_ack = 0;
    check("div_no_r5", n_wr5, 0);
    check("div_pulses", n_div, 1);

    // timeout: ready never arrives
    issue(1, 0, 5'd9, 32'd1, 32'd2);
    step();
    for (int i = 0; i < 40; i++) begin
      check("to_wait_wbv", wb_valid, 0);
      check("to_wait_busy", busy, 1);
      step();
    end
    check("to_wbv", wb_valid, 1);
    check("to_wbrd", wb_rd, 30);
    check("to_wbdata", wb_data, 4);
    wb_ack = 1;
    step();
    wb_ack = 0;
    check("to_idle", busy, 0);

    // writeback contention: ack withheld three cycles
    issue(1, 0, 5'd7, 32'd3, 32'd4);
    step();
    md_ready = 1; md_result = 32'hDEADBEEF;
    step();
    md_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check("wc_wbv", wb_valid, 1);
      check("wc_wbrd", wb_rd, 7);
      check("wc_wbdata", wb_data, 32'hDEADBEEF);
      check("wc_stall", stall_fd, 1);
      step();
    end
    wb_ack = 1;
    #1;
    check("wc_last_wbv", wb_valid, 1);
    step();
    wb_ack = 0;
    check("wc_done", busy, 0);

    // flushed div must not start
    x_valid = 1; x_div = 1; x_flush = 1;
    #1;
    check("fl_stall", stall_fd, 0);
    step();
    check("fl_busy", busy, 0);
    x_valid = 0; x_div = 0; x_flush = 0;
    step();
    check("fl_no_div", n_div, 1);

    // second mult during WAIT ignored
    issue(1, 0, 5'd2, 32'd5, 32'd5);
    step();
    x_valid = 1; x_mult = 1;
    step();
    step();
    x_valid = 0; x_mult = 0;
    md_ready = 1; md_result = 25;
    step();
    md_ready = 0;
    check("ig_wbdata", wb_data, 25);
    wb_ack = 1;
    step();
    wb_ack = 0;
    check("ig_pulses", n_mult, 4);

    // asynchronous reset mid-WAIT
    issue(1, 0, 5'd4, 32'd11, 32'd12);
    step();
    step();
    #2 reset = 0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_stall", stall_fd, 0);
    check("ar_opA", md_opA, 0);
    check("ar_opB", md_opB, 0);
    check("ar_ctrl", {md_ctrl_mult, md_ctrl_div, bubble_dx, wb_valid}, 0);
    md_ready = 1; md_result = 99;
    step();
    reset = 1;
    step();
    md_ready = 0;
    step();
    check("ar_no_wb", wb_valid, 0);
    check("ar_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Multi-cycle controller between the X stage and the shared iterative mult/div unit.
- Captures a decoded mult/div instruction and its operands when the instruction is in X.
- Pulses the unit's start control, then freezes the front of the pipeline until the unit reports ready or a timeout expires.
- Writes the result to rd through the writeback port; on an exception it writes the status value to r30 instead.

Parameters:
- MAX_CYCLES, 40: cycles allowed in WAIT before a timeout exception is forced.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- RSTATUS_MULT, 4: value written to r30 on a mult exception.
- RSTATUS_DIV, 5: value written to r30 on a div exception.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- x_valid  in  1  X stage holds a real instruction.
- x_mult  in  1  decoded mult in X.
- x_div  in  1  decoded div in X.
- x_rd  in  5  destination register of the X instruction.
- x_opA  in  32  rs operand, after bypass.
- x_opB  in  32  rt operand, after bypass.
- x_flush  in  1  X instruction is being squashed this cycle.
- md_ctrl_mult  out  1  one-cycle start pulse, multiply.
- md_ctrl_div  out  1  one-cycle start pulse, divide.
- md_opA  out  32  latched operand A.
- md_opB  out  32  latched operand B.
- md_result  in  32  unit result.
- md_exception  in  1  overflow or divide-by-zero; valid with md_ready.
- md_ready  in  1  result valid.
- stall_fd  out  1  hold PC and the F/D latch.
- bubble_dx  out  1  load a nop into the D/X latch.
- wb_valid  out  1  writeback request.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- wb_ack  in  1  writeback port granted this cycle.
- busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, WRITE, encoded in 2 bits.
- start = (state == IDLE) & x_valid & (x_mult | x_div) & ~x_flush.
- If x_mult and x_div are both set, treat the instruction as mult.
- IDLE -> ISSUE on start. At that edge, latch:
  - opA and opB onto md_opA/md_opB;
  - rd;
  - op (1 = div);
  - clear the counter.
- ISSUE: assert md_ctrl_mult or md_ctrl_div for exactly 1 cycle, then go to WAIT unconditionally.
- WAIT:
  - Counter increments each cycle.
  - On md_ready, capture the result and exception flag, then go to WRITE.
  - If the counter reaches MAX_CYCLES-1 without md_ready, force exception = 1 and go to WRITE.
  - md_ready seen in ISSUE is ignored.
- WRITE:
  - wb_valid = 1.
  - No exception: wb_rd = latched rd and wb_data = result.
  - Exception: wb_rd = 30 and wb_data = RSTATUS_MULT or RSTATUS_DIV, zero-extended to 32 bits.
  - Go to IDLE on the edge where wb_ack = 1; hold WRITE while wb_ack = 0.
- A latched rd of 0 with no exception still issues wb_valid; the register file discards writes to r0.
- stall_fd = bubble_dx = start | (state != IDLE). Both are combinational.
  - The start cycle loads a nop into D/X, which consumes the mult/div.
  - Both deassert in the first IDLE cycle after the wb_ack edge. The register file is therefore already written when the dependent D instruction reads it.
- x_mult and x_div are ignored outside IDLE.
- md_opA and md_opB hold their value until the next start.
- Minimum occupancy with md_ready in the first WAIT cycle and wb_ack immediate is 4 cycles: the start cycle, ISSUE, WAIT and WRITE, with stall_fd asserted in all four.
- Reset, asserted at any time (including mid-operation):
  - state goes to IDLE;
  - counter, latched data, md_opA and md_opB go to 0;
  - all outputs go to 0;
  - any in-flight unit result is dropped.
- Deassertion of reset is taken synchronously; no start is possible in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - REG_RSTATUS = 30;
  - RSTATUS_MULT and RSTATUS_DIV defaults;
  - the mult/div opcode and ALU-op constants (00000 / 00110 / 00111) reused by the decoder.
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- mult: opA = 7, opB = 6, rd = 3; unit ready with 42 after 16 cycles.
  - Exactly one md_ctrl_mult pulse.
  - stall_fd is high from the start cycle through WRITE.
  - wb_rd = 3, wb_data = 42 on wb_valid.
  - stall_fd low in the cycle after the wb_ack edge.
- div: opA = 100, opB = 0, rd = 5; unit returns md_exception = 1.
  - wb_rd = 30, wb_data = 5; rd 5 is never written.
- Timeout: mult with md_ready never asserted.
  - After 40 WAIT cycles the block enters WRITE with wb_rd = 30, wb_data = 4, then returns to IDLE after wb_ack.
- Writeback contention: result ready while wb_ack is held low for 3 cycles.
  - WRITE holds wb_valid, wb_rd and wb_data constant.
  - Stall is held throughout; the block completes on the 4th cycle.
- Flush gating: x_div with x_flush = 1.
  - No start, no md_ctrl_div, stall_fd = 0.
  - A second x_mult during WAIT is ignored: no second pulse.
- Reset mid-WAIT: assert reset asynchronously between clock edges.
  - All outputs 0 immediately; state IDLE.
  - A subsequent md_ready produces no writeback.
